// File: rtl/colour_sequence_player_if.sv
// Controller-side bus of the colour sequence player: push channel, playback control, lamp status.
interface colour_sequence_player_if #(
  parameter int unsigned NUM_COLOURS = 4,
  parameter int unsigned CW          = 2,
  parameter int unsigned DEPTH       = 16
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic                   clr;
  logic                   push_valid;
  logic [CW-1:0]          push_colour;
  logic                   push_ready;
  logic                   bad_code;
  logic                   start;
  logic [LW-1:0]          len;
  logic [NUM_COLOURS-1:0] lamp;
  logic                   busy;
  logic                   done;

  modport master (
    output clr, push_valid, push_colour, start,
    input  push_ready, bad_code, len, lamp, busy, done
  );

  modport slave (
    input  clr, push_valid, push_colour, start,
    output push_ready, bad_code, len, lamp, busy, done
  );
endinterface

// File: rtl/colour_sequence_player.sv
// Stores up to DEPTH colour codes and replays them as timed one-hot lamp pulses
// (ON_CYCLES lit, OFF_CYCLES dark per entry).
module colour_sequence_player #(
  parameter int unsigned NUM_COLOURS = 4,
  parameter int unsigned CW          = 2,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ON_CYCLES   = 8,
  parameter int unsigned OFF_CYCLES  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  colour_sequence_player_if.slave  io_bus
);
  localparam int unsigned LW   = $clog2(DEPTH) + 1;
  localparam int unsigned IW   = $clog2(DEPTH);
  localparam int unsigned TMax = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int unsigned TW   = (TMax > 1) ? $clog2(TMax) : 1;

  typedef enum logic [1:0] {StIdle, StOn, StOff} state_e;

  state_e                 r_state;
  logic [LW-1:0]          r_len;
  logic [IW-1:0]          r_idx;
  logic [TW-1:0]          r_timer;
  logic [NUM_COLOURS-1:0] r_lamp;
  logic                   r_done;
  logic                   r_bad_code;
  logic [CW-1:0]          r_mem [DEPTH];

  logic          w_push_ready;
  logic          w_push_acc;
  logic          w_code_ok;
  logic          w_wr;
  logic          w_eff_nonzero;
  logic          w_last;
  logic [IW-1:0] w_idx_nxt;
  logic [CW-1:0] w_first;

  function automatic logic [NUM_COLOURS-1:0] f_onehot(input logic [CW-1:0] code);
    logic [NUM_COLOURS-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_COLOURS; k++) begin
      v[k] = (code == CW'(k));
    end
    return v;
  endfunction

  assign w_push_ready  = (r_state == StIdle) && (r_len < LW'(DEPTH));
  assign w_push_acc    = io_bus.push_valid && w_push_ready && !io_bus.clr;
  assign w_code_ok     = ({1'b0, io_bus.push_colour} < (CW + 1)'(NUM_COLOURS));
  assign w_wr          = w_push_acc && w_code_ok;
  assign w_eff_nonzero = (r_len != '0) || w_wr;
  assign w_last        = ({1'b0, r_idx} == (r_len - LW'(1)));
  assign w_idx_nxt     = r_idx + IW'(1);
  // A push accepted alongside start with an empty store is the first entry to show.
  assign w_first       = (r_len == '0) ? io_bus.push_colour : r_mem[0];

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_len[IW-1:0]] <= io_bus.push_colour;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_len      <= '0;
      r_idx      <= '0;
      r_timer    <= '0;
      r_lamp     <= '0;
      r_done     <= 1'b0;
      r_bad_code <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_bad_code <= w_push_acc && !w_code_ok;
      if (io_bus.clr) begin
        r_state <= StIdle;
        r_len   <= '0;
        r_idx   <= '0;
        r_timer <= '0;
        r_lamp  <= '0;
      end else begin
        if (w_wr) begin
          r_len <= r_len + LW'(1);
        end
        unique case (r_state)
          StIdle: begin
            if (io_bus.start) begin
              if (w_eff_nonzero) begin
                r_state <= StOn;
                r_idx   <= '0;
                r_timer <= TW'(ON_CYCLES - 1);
                r_lamp  <= f_onehot(w_first);
              end else begin
                r_done <= 1'b1;
              end
            end
          end
          StOn: begin
            if (r_timer == '0) begin
              r_state <= StOff;
              r_timer <= TW'(OFF_CYCLES - 1);
              r_lamp  <= '0;
            end else begin
              r_timer <= r_timer - TW'(1);
            end
          end
          StOff: begin
            if (r_timer == '0) begin
              if (w_last) begin
                r_state <= StIdle;
                r_done  <= 1'b1;
              end else begin
                r_state <= StOn;
                r_idx   <= w_idx_nxt;
                r_timer <= TW'(ON_CYCLES - 1);
                r_lamp  <= f_onehot(r_mem[w_idx_nxt]);
              end
            end else begin
              r_timer <= r_timer - TW'(1);
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign io_bus.push_ready = w_push_ready;
  assign io_bus.bad_code   = r_bad_code;
  assign io_bus.len        = r_len;
  assign io_bus.lamp       = r_lamp;
  assign io_bus.busy       = (r_state != StIdle);
  assign io_bus.done       = r_done;
endmodule

// File: tb/tb_colour_sequence_player.sv
// Directed bench for colour_sequence_player: defaults, a small-depth/3-colour build and a
// fast 8-colour build.
module tb_colour_sequence_player;
  logic clk;
  logic rst_n;

  int n_checks;
  int n_errors;

  colour_sequence_player_if #(.NUM_COLOURS(4), .CW(2), .DEPTH(16)) if_a ();
  colour_sequence_player_if #(.NUM_COLOURS(3), .CW(2), .DEPTH(4))  if_b ();
  colour_sequence_player_if #(.NUM_COLOURS(8), .CW(3), .DEPTH(16)) if_c ();

  colour_sequence_player #(
    .NUM_COLOURS(4), .CW(2), .DEPTH(16), .ON_CYCLES(8), .OFF_CYCLES(4)
  ) u_dut_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (if_a)
  );

  colour_sequence_player #(
    .NUM_COLOURS(3), .CW(2), .DEPTH(4), .ON_CYCLES(8), .OFF_CYCLES(4)
  ) u_dut_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (if_b)
  );

  colour_sequence_player #(
    .NUM_COLOURS(8), .CW(3), .DEPTH(16), .ON_CYCLES(1), .OFF_CYCLES(1)
  ) u_dut_c (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (if_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [1:0] code);
    if_a.push_valid  = 1'b1;
    if_a.push_colour = code;
    tick();
    if_a.push_valid  = 1'b0;
  endtask

  task automatic push_b(input logic [1:0] code);
    if_b.push_valid  = 1'b1;
    if_b.push_colour = code;
    tick();
    if_b.push_valid  = 1'b0;
  endtask

  task automatic push_c(input logic [2:0] code);
    if_c.push_valid  = 1'b1;
    if_c.push_colour = code;
    tick();
    if_c.push_valid  = 1'b0;
  endtask

  logic [31:0] exp_lamp;
  logic [7:0]  lamp_c_tbl [6];
  int          busy_cnt;
  int          done_cnt;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    {if_a.clr, if_a.push_valid, if_a.push_colour, if_a.start} = '0;
    {if_b.clr, if_b.push_valid, if_b.push_colour, if_b.start} = '0;
    {if_c.clr, if_c.push_valid, if_c.push_colour, if_c.start} = '0;
    lamp_c_tbl[0] = 8'h80; lamp_c_tbl[1] = 8'h00; lamp_c_tbl[2] = 8'h01;
    lamp_c_tbl[3] = 8'h00; lamp_c_tbl[4] = 8'h20; lamp_c_tbl[5] = 8'h00;

    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("rst_push_ready", 32'(if_a.push_ready), 32'd1);
    check_eq("rst_len",        32'(if_a.len),        32'd0);
    check_eq("rst_lamp",       32'(if_a.lamp),       32'd0);
    check_eq("rst_busy",       32'(if_a.busy),       32'd0);
    check_eq("rst_done",       32'(if_a.done),       32'd0);

    // Basic playback 0,1,2,3
    push_a(2'd0); push_a(2'd1); push_a(2'd2); push_a(2'd3);
    check_eq("basic_len_before", 32'(if_a.len), 32'd4);
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    for (int t = 0; t < 48; t++) begin
      exp_lamp = ((t % 12) < 8) ? (32'd1 << (t / 12)) : 32'd0;
      check_eq($sformatf("basic_lamp_t%0d", t), 32'(if_a.lamp), exp_lamp);
      check_eq($sformatf("basic_busy_t%0d", t), 32'(if_a.busy), 32'd1);
      check_eq($sformatf("basic_done_t%0d", t), 32'(if_a.done), 32'd0);
      if (t == 0) check_eq("busy_push_ready", 32'(if_a.push_ready), 32'd0);
      tick();
    end
    check_eq("basic_end_busy",  32'(if_a.busy), 32'd0);
    check_eq("basic_end_done",  32'(if_a.done), 32'd1);
    check_eq("basic_end_ready", 32'(if_a.push_ready), 32'd1);
    tick();
    check_eq("basic_done_once", 32'(if_a.done), 32'd0);
    check_eq("basic_len_after", 32'(if_a.len), 32'd4);

    // Async reset in the middle of the third colour
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    repeat (26) tick();
    check_eq("pre_rst_lamp", 32'(if_a.lamp), 32'h4);
    #1 rst_n = 1'b0;
    #1;
    check_eq("async_rst_lamp", 32'(if_a.lamp), 32'd0);
    check_eq("async_rst_busy", 32'(if_a.busy), 32'd0);
    check_eq("async_rst_done", 32'(if_a.done), 32'd0);
    check_eq("async_rst_len",  32'(if_a.len),  32'd0);
    #2 rst_n = 1'b1;
    tick();
    check_eq("post_rst_ready", 32'(if_a.push_ready), 32'd1);

    // Push coinciding with start, then an ignored push while busy
    push_a(2'd2);
    if_a.push_valid  = 1'b1;
    if_a.push_colour = 2'd1;
    if_a.start       = 1'b1;
    tick();
    if_a.push_valid = 1'b0;
    if_a.start      = 1'b0;
    check_eq("sim_len", 32'(if_a.len), 32'd2);
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 0)  check_eq("sim_lamp0", 32'(if_a.lamp), 32'h4);
      if (i == 12) check_eq("sim_lamp1", 32'(if_a.lamp), 32'h2);
      if (if_a.busy) busy_cnt++;
      if (if_a.done) done_cnt++;
      if (i == 1) begin
        if_a.push_valid  = 1'b1;
        if_a.push_colour = 2'd3;
      end else begin
        if_a.push_valid = 1'b0;
      end
      tick();
    end
    check_eq("sim_busy_cycles", 32'(busy_cnt), 32'd24);
    check_eq("sim_done_pulses", 32'(done_cnt), 32'd1);
    check_eq("sim_len_after",   32'(if_a.len), 32'd2);
    check_eq("sim_bad_code",    32'(if_a.bad_code), 32'd0);

    // clr, then zero-length start
    if_a.clr = 1'b1;
    tick();
    if_a.clr = 1'b0;
    check_eq("clr_len", 32'(if_a.len), 32'd0);
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    check_eq("zero_done", 32'(if_a.done), 32'd1);
    check_eq("zero_busy", 32'(if_a.busy), 32'd0);
    tick();
    check_eq("zero_done_once", 32'(if_a.done), 32'd0);
    check_eq("zero_busy_after", 32'(if_a.busy), 32'd0);

    // clr in the middle of ON of a 3-entry sequence
    push_a(2'd1); push_a(2'd2); push_a(2'd3);
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    repeat (3) tick();
    check_eq("clr_mid_lamp_pre", 32'(if_a.lamp), 32'h2);
    if_a.clr = 1'b1;
    tick();
    if_a.clr = 1'b0;
    check_eq("clr_mid_busy", 32'(if_a.busy), 32'd0);
    check_eq("clr_mid_lamp", 32'(if_a.lamp), 32'd0);
    check_eq("clr_mid_len",  32'(if_a.len),  32'd0);
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (if_a.done || if_a.busy) done_cnt++;
      tick();
    end
    check_eq("clr_mid_no_done", 32'(done_cnt), 32'd0);

    // Bad code and full store on the 3-colour, depth-4 build
    push_b(2'd3);
    check_eq("bad_pulse", 32'(if_b.bad_code), 32'd1);
    check_eq("bad_len",   32'(if_b.len),      32'd0);
    tick();
    check_eq("bad_pulse_once", 32'(if_b.bad_code), 32'd0);
    push_b(2'd0); push_b(2'd1); push_b(2'd2);
    check_eq("fill_ready3", 32'(if_b.push_ready), 32'd1);
    push_b(2'd0);
    check_eq("full_len",   32'(if_b.len),        32'd4);
    check_eq("full_ready", 32'(if_b.push_ready), 32'd0);
    push_b(2'd3);
    check_eq("full_len_sat",  32'(if_b.len),      32'd4);
    check_eq("full_no_bad",   32'(if_b.bad_code), 32'd0);

    // Fast 8-colour build, codes 7,0,5
    push_c(3'd7); push_c(3'd0); push_c(3'd5);
    if_c.start = 1'b1;
    tick();
    if_c.start = 1'b0;
    for (int t = 0; t < 6; t++) begin
      check_eq($sformatf("c_lamp_t%0d", t), 32'(if_c.lamp), 32'(lamp_c_tbl[t]));
      check_eq($sformatf("c_busy_t%0d", t), 32'(if_c.busy), 32'd1);
      tick();
    end
    check_eq("c_done", 32'(if_c.done), 32'd1);
    check_eq("c_idle", 32'(if_c.busy), 32'd0);
    check_eq("c_lamp_end", 32'(if_c.lamp), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
